// File: rtl/pi_dma_seq_pkg.sv
// Shared definitions for the cartridge-bus block-copy sequencer.
// Contains the memory-select codes, the FSM state encoding and the bus widths.
package pi_dma_seq_pkg;

   localparam int unsigned AddrW = 23;
   localparam int unsigned LenW  = 16;

   typedef enum logic [1:0] {
      MemPrg = 2'd0,
      MemChr = 2'd1,
      MemSrm = 2'd2,
      MemRsv = 2'd3
   } mem_sel_e;

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StWrSu,
      StWrPl,
      StWrHd,
      StPause,
      StDone
   } state_e;

   // Chip-enable vector ordered {srm, chr, prg}
   function automatic logic [2:0] ce_onehot(mem_sel_e sel);
      logic [2:0] ce;
      unique case (sel)
         MemPrg:  ce = 3'b001;
         MemChr:  ce = 3'b010;
         MemSrm:  ce = 3'b100;
         default: ce = 3'b000;
      endcase
      return ce;
   endfunction

endpackage

// File: rtl/pi_dma_seq_if.sv
// Cartridge memory bus plus host arbitration signals shared by the sequencer
// (master) and the memories / host PI side (slave).
interface pi_dma_seq_if;
   import pi_dma_seq_pkg::*;

   logic [AddrW-1:0] mem_addr;
   logic             mem_ce_prg;
   logic             mem_ce_chr;
   logic             mem_ce_srm;
   logic             mem_oe;
   logic             mem_we;
   logic [7:0]       mem_do;
   logic [7:0]       mem_di;
   logic             host_req;
   logic             host_gnt;
   logic             dma_req;

   modport master (
      output mem_addr, mem_ce_prg, mem_ce_chr, mem_ce_srm, mem_oe, mem_we, mem_do,
      output host_gnt, dma_req,
      input  mem_di, host_req
   );

   modport slave (
      input  mem_addr, mem_ce_prg, mem_ce_chr, mem_ce_srm, mem_oe, mem_we, mem_do,
      input  host_gnt, dma_req,
      output mem_di, host_req
   );

endinterface

// File: rtl/pi_dma_seq_wait_cnt.sv
// Loadable down-counter timing the read and write strobe phases.
// Saturates at zero; zero flag is combinational from the count register.
module pi_dma_seq_wait_cnt #(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [Width-1:0] load_val,
   output logic             zero
);

   logic [Width-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/pi_dma_seq.sv
// Byte-by-byte block copy between PRG/CHR/SRM with programmable strobe widths,
// yielding the bus to the host PI between bytes. All outputs are registered.
module pi_dma_seq
   import pi_dma_seq_pkg::*;
#(
   parameter int unsigned T_RD = 2,
   parameter int unsigned T_WR = 2
) (
   input  logic             clk,
   input  logic             map_rst,
   input  logic             start,
   input  logic             abort,
   input  logic [AddrW-1:0] cfg_src,
   input  logic [AddrW-1:0] cfg_dst,
   input  logic [1:0]       cfg_src_mem,
   input  logic [1:0]       cfg_dst_mem,
   input  logic [LenW-1:0]  cfg_len,
   output logic             busy,
   output logic             done,
   output logic             err,
   pi_dma_seq_if.master     bus
);

   localparam int unsigned CntW = 8;

   state_e           state_q, state_d;
   logic [AddrW-1:0] src_q, src_d, dst_q, dst_d;
   logic [LenW-1:0]  rem_q, rem_d;
   mem_sel_e         smem_q, smem_d, dmem_q, dmem_d;
   logic             err_q, err_d;
   logic             capture;
   logic             cnt_zero;

   logic             busy_q, busy_d;
   logic             done_q;
   logic             gnt_q, gnt_d;
   logic             dreq_q, dreq_d;
   logic [AddrW-1:0] addr_q, addr_d;
   logic [2:0]       ce_q, ce_d;
   logic             oe_q, oe_d;
   logic             we_q, we_d;
   logic [7:0]       do_q;

   // Reloaded on every state change; RD and WR_PL hold until it reaches zero.
   pi_dma_seq_wait_cnt #(
      .Width (CntW)
   ) u_wait_cnt (
      .clk      (clk),
      .rst      (map_rst),
      .load     (state_d != state_q),
      .load_val ((state_d == StWrPl) ? CntW'(T_WR) : CntW'(T_RD)),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      rem_d   = rem_q;
      smem_d  = smem_q;
      dmem_d  = dmem_q;
      err_d   = err_q;
      capture = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               src_d  = cfg_src;
               dst_d  = cfg_dst;
               rem_d  = cfg_len;
               smem_d = mem_sel_e'(cfg_src_mem);
               dmem_d = mem_sel_e'(cfg_dst_mem);
               err_d  = 1'b0;
               if (cfg_len == '0) begin
                  state_d = StDone;
               end else if (smem_d == MemRsv || dmem_d == MemRsv) begin
                  state_d = StDone;
                  err_d   = 1'b1;
               end else if (gnt_q) begin
                  state_d = StPause;
               end else begin
                  state_d = StRd;
               end
            end
         end
         StRd: begin
            if (cnt_zero) begin
               capture = 1'b1;
               state_d = StWrSu;
            end
         end
         StWrSu: state_d = StWrPl;
         StWrPl: begin
            if (cnt_zero) state_d = StWrHd;
         end
         StWrHd: begin
            src_d = src_q + 1'b1;
            dst_d = dst_q + 1'b1;
            rem_d = rem_q - 1'b1;
            if (rem_d == '0) begin
               state_d = StDone;
            end else if (abort) begin
               state_d = StDone;
               err_d   = 1'b1;
            end else if (bus.host_req) begin
               state_d = StPause;
            end else begin
               state_d = StRd;
            end
         end
         StPause: begin
            if (abort) begin
               state_d = StDone;
               err_d   = 1'b1;
            end else if (!bus.host_req) begin
               state_d = StRd;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs are decoded from the next state so the registers line up with state_q.
   always_comb begin
      addr_d = addr_q;
      ce_d   = 3'b000;
      oe_d   = 1'b0;
      we_d   = 1'b0;
      unique case (state_d)
         StRd: begin
            addr_d = src_d;
            ce_d   = ce_onehot(smem_d);
            oe_d   = 1'b1;
         end
         StWrSu, StWrHd: begin
            addr_d = dst_d;
            ce_d   = ce_onehot(dmem_d);
         end
         StWrPl: begin
            addr_d = dst_d;
            ce_d   = ce_onehot(dmem_d);
            we_d   = 1'b1;
         end
         default: ;
      endcase
   end

   assign busy_d = state_d inside {StRd, StWrSu, StWrPl, StWrHd, StPause};
   assign gnt_d  = (state_d == StPause) || (state_d == StIdle && bus.host_req);
   assign dreq_d = busy_d && !gnt_d;

   always_ff @(posedge clk) begin
      if (map_rst) begin
         state_q <= StIdle;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         smem_q  <= MemPrg;
         dmem_q  <= MemPrg;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         gnt_q   <= 1'b0;
         dreq_q  <= 1'b0;
         addr_q  <= '0;
         ce_q    <= 3'b000;
         oe_q    <= 1'b0;
         we_q    <= 1'b0;
         do_q    <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         smem_q  <= smem_d;
         dmem_q  <= dmem_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= (state_d == StDone);
         gnt_q   <= gnt_d;
         dreq_q  <= dreq_d;
         addr_q  <= addr_d;
         ce_q    <= ce_d;
         oe_q    <= oe_d;
         we_q    <= we_d;
         if (capture) do_q <= bus.mem_di;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign err            = err_q;
   assign bus.host_gnt   = gnt_q;
   assign bus.dma_req    = dreq_q;
   assign bus.mem_addr   = addr_q;
   assign bus.mem_ce_prg = ce_q[0];
   assign bus.mem_ce_chr = ce_q[1];
   assign bus.mem_ce_srm = ce_q[2];
   assign bus.mem_oe     = oe_q;
   assign bus.mem_we     = we_q;
   assign bus.mem_do     = do_q;

endmodule

// File: tb/tb_pi_dma_seq.sv
// Scoreboard bench for pi_dma_seq: a byte-level copy model predicts every write
// and done pulse; a negedge monitor plays the memories and checks the bus.
module tb_pi_dma_seq;
   import pi_dma_seq_pkg::*;

   localparam int unsigned T_RD    = 2;
   localparam int unsigned T_WR    = 2;
   localparam int unsigned ByteCyc = T_RD + T_WR + 4;

   logic        clk = 1'b0;
   logic        map_rst;
   logic        start;
   logic        abort;
   logic [22:0] cfg_src;
   logic [22:0] cfg_dst;
   logic [1:0]  cfg_src_mem;
   logic [1:0]  cfg_dst_mem;
   logic [15:0] cfg_len;
   logic        busy;
   logic        done;
   logic        err;

   pi_dma_seq_if bus();

   pi_dma_seq #(
      .T_RD (T_RD),
      .T_WR (T_WR)
   ) dut (
      .clk         (clk),
      .map_rst     (map_rst),
      .start       (start),
      .abort       (abort),
      .cfg_src     (cfg_src),
      .cfg_dst     (cfg_dst),
      .cfg_src_mem (cfg_src_mem),
      .cfg_dst_mem (cfg_dst_mem),
      .cfg_len     (cfg_len),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  mem;
      logic [22:0] addr;
      logic [7:0]  data;
   } wr_t;

   int          checks = 0;
   int          errors = 0;
   wr_t         exp_wr[$];
   logic        exp_done[$];
   logic [22:0] rd_log[$];
   logic [7:0]  ref_mem[int];
   logic [7:0]  dev_mem[int];
   int          wr_cnt = 0;
   int          done_cnt = 0;
   logic        host_cmd = 1'b0;
   logic        rnd_host = 1'b0;
   logic        rnd_val = 1'b0;

   function automatic int mkey(logic [1:0] m, logic [22:0] a);
      return int'({7'd0, m, a});
   endfunction

   function automatic logic [7:0] init_byte(int k);
      logic [31:0] h;
      h = (k * 37) ^ (k >> 7) ^ 32'h5a;
      return h[7:0];
   endfunction

   function automatic logic [7:0] ref_rd(int k);
      if (ref_mem.exists(k)) return ref_mem[k];
      return init_byte(k);
   endfunction

   function automatic logic [7:0] dev_rd(int k);
      if (dev_mem.exists(k)) return dev_mem[k];
      return init_byte(k);
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Sequential byte copy: each byte is read after all earlier bytes were written.
   task automatic ref_copy(logic [22:0] s, logic [22:0] d, logic [1:0] sm, logic [1:0] dm,
                           int nb, logic e, logic push_done);
      for (int i = 0; i < nb; i++) begin
         logic [22:0] sa;
         logic [22:0] da;
         logic [7:0]  b;
         sa = s + 23'(i);
         da = d + 23'(i);
         b  = ref_rd(mkey(sm, sa));
         ref_mem[mkey(dm, da)] = b;
         exp_wr.push_back('{mem: dm, addr: da, data: b});
      end
      if (push_done) exp_done.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(logic [22:0] s, logic [22:0] d, logic [1:0] sm, logic [1:0] dm,
                           logic [15:0] len);
      cfg_src     = s;
      cfg_dst     = d;
      cfg_src_mem = sm;
      cfg_dst_mem = dm;
      cfg_len     = len;
      start       = 1'b1;
      tick();
      start       = 1'b0;
   endtask

   task automatic wait_done(int base, int limit, string name);
      int n;
      n = 0;
      while (done_cnt == base && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(name, done_cnt - base, 1);
      tick();
   endtask

   // Cycles counted from the edge that accepted start; also tracks CHR enable runs.
   task automatic observe(output int done_at, output int ce_runs, output int ce_bad,
                          output int act);
      int cyc;
      int ce_len;
      cyc = 0; ce_len = 0; done_at = -1; ce_runs = 0; ce_bad = 0; act = 0;
      while (done_at < 0 && cyc < 200) begin
         @(negedge clk);
         if (done) done_at = cyc;
         if (bus.mem_ce_prg || bus.mem_ce_chr || bus.mem_ce_srm || bus.mem_oe || bus.mem_we)
            act++;
         if (bus.mem_ce_chr) begin
            ce_len++;
         end else if (ce_len != 0) begin
            ce_runs++;
            if (ce_len != int'(T_WR) + 3) ce_bad++;
            ce_len = 0;
         end
         cyc++;
      end
      tick();
   endtask

   always @(negedge clk) begin
      if (rnd_host && $urandom_range(0, 15) == 0) rnd_val = ~rnd_val;
      bus.host_req = rnd_host ? rnd_val : host_cmd;
   end

   logic we_p = 1'b0;
   logic oe_p = 1'b0;
   int   we_len = 0;

   // Memory device plus scoreboard monitor.
   always @(negedge clk) begin
      logic [2:0] ce;
      logic [1:0] selb;
      wr_t        e;
      ce   = {bus.mem_ce_srm, bus.mem_ce_chr, bus.mem_ce_prg};
      selb = bus.mem_ce_chr ? 2'd1 : (bus.mem_ce_srm ? 2'd2 : 2'd0);
      bus.mem_di = (bus.mem_oe && $countones(ce) == 1) ? dev_rd(mkey(selb, bus.mem_addr)) : 8'h00;
      if (map_rst) begin
         we_p = 1'b0; oe_p = 1'b0; we_len = 0;
      end else begin
         if (bus.mem_oe && !oe_p) rd_log.push_back(bus.mem_addr);
         oe_p = bus.mem_oe;
         if (bus.mem_we && !we_p) begin
            check("write_ce_onehot", $countones(ce), 1);
            dev_mem[mkey(selb, bus.mem_addr)] = bus.mem_do;
            wr_cnt++;
            if (exp_wr.size() == 0) begin
               check("unexpected_write", {selb, bus.mem_addr, bus.mem_do}, 0);
            end else begin
               e = exp_wr.pop_front();
               check("write_mem_addr_data", {selb, bus.mem_addr, bus.mem_do}, e);
            end
         end
         if (bus.mem_we) begin
            we_len++;
         end else if (we_p) begin
            check("we_width", we_len, T_WR + 1);
            we_len = 0;
         end
         we_p = bus.mem_we;
         if (done) begin
            done_cnt++;
            if (exp_done.size() == 0) check("unexpected_done", 1, 0);
            else check("done_err", err, exp_done.pop_front());
         end
         if (bus.host_gnt)
            check("bus_idle_while_gnt", {ce, bus.mem_oe, bus.mem_we, bus.dma_req}, 0);
      end
   end

   initial begin
      int base, w0, n, done_at, ce_runs, ce_bad, act, mism, oe_rises;
      logic bad, oe_prev;
      map_rst = 1'b1; start = 1'b0; abort = 1'b0;
      cfg_src = '0; cfg_dst = '0; cfg_src_mem = '0; cfg_dst_mem = '0; cfg_len = '0;
      repeat (3) tick();
      @(negedge clk);
      check("reset_outputs", {busy, done, err, bus.host_gnt, bus.dma_req, bus.mem_ce_prg,
            bus.mem_ce_chr, bus.mem_ce_srm, bus.mem_oe, bus.mem_we, bus.mem_addr, bus.mem_do}, 0);
      tick();
      map_rst = 1'b0;
      tick();

      // PRG -> CHR, four bytes
      ref_copy(23'h000100, 23'h000200, 2'd0, 2'd1, 4, 1'b0, 1'b1);
      do_start(23'h000100, 23'h000200, 2'd0, 2'd1, 16'd4);
      observe(done_at, ce_runs, ce_bad, act);
      check("copy4_done_latency", done_at, 4 * ByteCyc);
      check("copy4_ce_runs", ce_runs, 4);
      check("copy4_ce_envelope", ce_bad, 0);
      for (int i = 0; i < 4; i++)
         check("copy4_chr_data", dev_rd(mkey(2'd1, 23'h200 + 23'(i))),
               init_byte(mkey(2'd0, 23'h100 + 23'(i))));

      // Zero length
      ref_copy(23'h10, 23'h20, 2'd0, 2'd2, 0, 1'b0, 1'b1);
      do_start(23'h10, 23'h20, 2'd0, 2'd2, 16'd0);
      observe(done_at, ce_runs, ce_bad, act);
      check("len0_done_latency", done_at, 0);
      check("len0_no_bus", act, 0);
      check("len0_err", err, 0);

      // Reserved source memory, then a valid start clears err
      ref_copy(23'h10, 23'h20, 2'd3, 2'd1, 0, 1'b1, 1'b1);
      do_start(23'h10, 23'h20, 2'd3, 2'd1, 16'd2);
      observe(done_at, ce_runs, ce_bad, act);
      check("rsv_done_latency", done_at, 0);
      check("rsv_no_bus", act, 0);
      check("rsv_err_sticky", err, 1);
      base = done_cnt;
      ref_copy(23'h300, 23'h310, 2'd0, 2'd0, 1, 1'b0, 1'b1);
      do_start(23'h300, 23'h310, 2'd0, 2'd0, 16'd1);
      @(negedge clk);
      check("err_cleared_on_start", {busy, err}, 2'b10);
      wait_done(base, 100, "single_done");

      // Host request during byte 2 of 5
      base = done_cnt; w0 = wr_cnt;
      ref_copy(23'h000400, 23'h000500, 2'd2, 2'd0, 5, 1'b0, 1'b1);
      do_start(23'h000400, 23'h000500, 2'd2, 2'd0, 16'd5);
      n = 0; oe_rises = 0; oe_prev = 1'b0;
      while (oe_rises < 2 && n < 100) begin
         @(negedge clk);
         if (bus.mem_oe && !oe_prev) oe_rises++;
         oe_prev = bus.mem_oe;
         n++;
      end
      tick();
      host_cmd = 1'b1;
      n = 0;
      while (!bus.host_gnt && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("host_gnt_latency", (n <= int'(ByteCyc)) && bus.host_gnt, 1);
      check("bytes_before_pause", wr_cnt - w0, 2);
      bad = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (bus.dma_req || !bus.host_gnt) bad = 1'b1;
      end
      check("dma_req_low_in_pause", bad, 0);
      check("no_write_in_pause", wr_cnt - w0, 2);
      tick();
      host_cmd = 1'b0;
      wait_done(base, 200, "pause_copy_done");
      check("pause_total_bytes", wr_cnt - w0, 5);

      // Abort during the third byte's write pulse of ten
      base = done_cnt; w0 = wr_cnt;
      ref_copy(23'h000600, 23'h000700, 2'd0, 2'd2, 3, 1'b1, 1'b1);
      do_start(23'h000600, 23'h000700, 2'd0, 2'd2, 16'd10);
      n = 0;
      while (wr_cnt - w0 < 3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      abort = 1'b1;
      wait_done(base, 100, "abort_done");
      abort = 1'b0;
      check("abort_bytes_written", wr_cnt - w0, 3);
      check("abort_err", err, 1);

      // Address wrap at the top of the 23-bit space
      base = done_cnt;
      rd_log.delete();
      ref_copy(23'h7ffffe, 23'h7fffff, 2'd1, 2'd1, 3, 1'b0, 1'b1);
      do_start(23'h7ffffe, 23'h7fffff, 2'd1, 2'd1, 16'd3);
      wait_done(base, 100, "wrap_done");
      check("wrap_read_count", rd_log.size(), 3);
      if (rd_log.size() == 3)
         check("wrap_read_addrs", {rd_log[0], rd_log[1], rd_log[2]},
               {23'h7ffffe, 23'h7fffff, 23'h000000});

      // Reset in the middle of a write pulse
      ref_copy(23'h000040, 23'h000080, 2'd0, 2'd2, 1, 1'b0, 1'b0);
      do_start(23'h000040, 23'h000080, 2'd0, 2'd2, 16'd3);
      n = 0;
      while (!bus.mem_we && n < 100) begin
         @(negedge clk);
         n++;
      end
      tick();
      map_rst = 1'b1;
      tick();
      @(negedge clk);
      check("midwrite_reset_outputs", {busy, done, err, bus.host_gnt, bus.dma_req,
            bus.mem_ce_prg, bus.mem_ce_chr, bus.mem_ce_srm, bus.mem_oe, bus.mem_we,
            bus.mem_addr, bus.mem_do}, 0);
      map_rst = 1'b0;
      tick();

      // Randomized copies with random host traffic
      rnd_host = 1'b1;
      for (int t = 0; t < 25; t++) begin
         logic [22:0] s, d;
         logic [1:0]  sm, dm;
         logic [15:0] len;
         s   = ($urandom_range(0, 3) == 0) ? 23'($urandom) : 23'($urandom_range(0, 63));
         d   = ($urandom_range(0, 3) == 0) ? 23'($urandom) : 23'($urandom_range(0, 63));
         sm  = 2'($urandom_range(0, 2));
         dm  = 2'($urandom_range(0, 2));
         len = 16'($urandom_range(1, 6));
         base = done_cnt;
         ref_copy(s, d, sm, dm, int'(len), 1'b0, 1'b1);
         do_start(s, d, sm, dm, len);
         wait_done(base, 1000, "random_done");
      end
      rnd_host = 1'b0;
      repeat (3) tick();

      check("write_queue_drained", exp_wr.size(), 0);
      check("done_queue_drained", exp_done.size(), 0);
      mism = 0;
      foreach (ref_mem[k]) if (dev_rd(k) !== ref_mem[k]) mism++;
      foreach (dev_mem[k]) if (ref_rd(k) !== dev_mem[k]) mism++;
      check("memory_image", mism, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
